// File: rtl/ps2_key_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ps2_key_fifo
// Brief   : Key-event FIFO. Optional code filter: PS2_KEY_FIFO_FILTER_EN
// Revision: 1.0 - initial release
// ============================================================================
module ps2_key_fifo #(
   parameter int DEPTH      = 16,
   parameter int SAMPLE_DLY = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       key_valid,
   input  logic [7:0]                 key_code,
   input  logic                       rd_en,
   input  logic                       clr_ovf,
   output logic [7:0]                 rd_data,
   output logic                       rd_valid,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
`ifdef PS2_KEY_FIFO_FILTER_EN
   output logic [7:0]                 drop_cnt,
`endif
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [7:0] UNMAPPED_CODE = 8'hFE;

   logic          wr_req;
   logic          wr_keep;
   logic          rd_acc;
   logic          wr_ok;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          overflow_q, overflow_d;

   // key_code lags its strobe by SAMPLE_DLY clocks, so delay the strobe to match
   generate
      if (SAMPLE_DLY == 0) begin : g_no_dly
         assign wr_req = key_valid;
      end else begin : g_dly
         logic [SAMPLE_DLY-1:0] dly_q, dly_d;

         always_comb begin
            dly_d = (dly_q << 1) | SAMPLE_DLY'(key_valid);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               dly_q <= '0;
            end else begin
               dly_q <= dly_d;
            end
         end

         assign wr_req = dly_q[SAMPLE_DLY-1];
      end
   endgenerate

`ifdef PS2_KEY_FIFO_FILTER_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   assign wr_keep = wr_req && (key_code != UNMAPPED_CODE);

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (wr_req && (key_code == UNMAPPED_CODE) && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= 8'h00;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign wr_keep = wr_req;
`endif

   // No bypass: a read is only accepted against already-stored entries
   assign rd_acc = rd_en && !empty_q;
   assign wr_ok  = wr_keep && (!full_q || rd_acc);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;
      overflow_d = overflow_q;

      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end

      case ({wr_ok, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));

      if (wr_keep && !wr_ok) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset; pointers and count define what is valid
   always_ff @(posedge clk) begin
      if (wr_ok && !rst) begin
         mem_q[wr_ptr_q] <= key_code;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_key_fifo
// Brief   : Directed self-checking bench for ps2_key_fifo (DEPTH=16, SAMPLE_DLY=1)
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_key_fifo;

   logic       clk;
   logic       rst;
   logic       key_valid;
   logic [7:0] key_code;
   logic       rd_en;
   logic       clr_ovf;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
`ifdef PS2_KEY_FIFO_FILTER_EN
   logic [7:0] drop_cnt;
`endif

   int checks;
   int failures;

   ps2_key_fifo #(
      .DEPTH      (16),
      .SAMPLE_DLY (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .rd_en     (rd_en),
      .clr_ovf   (clr_ovf),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .empty     (empty),
      .full      (full),
      .count     (count),
`ifdef PS2_KEY_FIFO_FILTER_EN
      .drop_cnt  (drop_cnt),
`endif
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Strobe carries a decoy code; the real code follows one clock later
   task automatic push(input logic [7:0] code);
      key_valid = 1'b1;
      key_code  = 8'hEE;
      tick();
      key_valid = 1'b0;
      key_code  = code;
      tick();
      key_code  = 8'h00;
   endtask

   task automatic pop(input string tag, input logic [7:0] exp);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_data"}, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      key_valid = 1'b0;
      key_code  = 8'h00;
      rd_en     = 1'b0;
      clr_ovf   = 1'b0;
      tick();
      tick();
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'h00);
      check("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      tick();

      // Single write then read
      push(8'h41);
      check("one_count", 32'(count), 32'd1);
      check("one_empty", 32'(empty), 32'd0);
      pop("one_pop", 8'h41);
      check("one_empty_after", 32'(empty), 32'd1);
      tick();
      check("rd_valid_pulse", 32'(rd_valid), 32'd0);

      // Fill to DEPTH, then one dropped write
      for (int i = 0; i < 16; i++) push(8'h51 + 8'(i));
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd16);
      check("fill_ovf_clear", 32'(overflow), 32'd0);
      push(8'h61);
      check("drop_ovf", 32'(overflow), 32'd1);
      check("drop_count", 32'(count), 32'd16);

      // clr_ovf coincident with a new drop: set wins
      key_valid = 1'b1;
      key_code  = 8'hEE;
      tick();
      key_valid = 1'b0;
      key_code  = 8'h62;
      clr_ovf   = 1'b1;
      tick();
      clr_ovf   = 1'b0;
      check("setwins_ovf", 32'(overflow), 32'd1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("clr_ovf", 32'(overflow), 32'd0);

      // Full: simultaneous write and read
      key_valid = 1'b1;
      key_code  = 8'hEE;
      tick();
      key_valid = 1'b0;
      key_code  = 8'h5A;
      rd_en     = 1'b1;
      tick();
      rd_en     = 1'b0;
      check("rw_full_valid", 32'(rd_valid), 32'd1);
      check("rw_full_data", 32'(rd_data), 32'h51);
      check("rw_full_count", 32'(count), 32'd16);
      check("rw_full_ovf", 32'(overflow), 32'd0);
      for (int i = 1; i < 16; i++) pop("drain", 8'h51 + 8'(i));
      pop("drain_last", 8'h5A);
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_count", 32'(count), 32'd0);

      // Read while empty with a simultaneous write: write only
      key_valid = 1'b1;
      key_code  = 8'hEE;
      tick();
      key_valid = 1'b0;
      key_code  = 8'h4D;
      rd_en     = 1'b1;
      tick();
      rd_en     = 1'b0;
      check("emptyrw_valid", 32'(rd_valid), 32'd0);
      check("emptyrw_data_hold", 32'(rd_data), 32'h5A);
      check("emptyrw_count", 32'(count), 32'd1);
      pop("emptyrw_pop", 8'h4D);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("empty_rd_valid", 32'(rd_valid), 32'd0);
      check("empty_rd_hold", 32'(rd_data), 32'h4D);

`ifdef PS2_KEY_FIFO_FILTER_EN
      push(8'hFE);
      push(8'h45);
      check("filt_count", 32'(count), 32'd1);
      check("filt_drop_cnt", 32'(drop_cnt), 32'd1);
      check("filt_ovf", 32'(overflow), 32'd0);
      pop("filt_pop", 8'h45);
`else
      push(8'hFE);
      check("fe_count", 32'(count), 32'd1);
      pop("fe_pop", 8'hFE);
`endif

      // Reset mid-stream with a strobe in the pipeline and a read pending
      push(8'h71);
      push(8'h72);
      push(8'h73);
      key_valid = 1'b1;
      key_code  = 8'h74;
      rd_en     = 1'b1;
      rst       = 1'b1;
      tick();
      key_valid = 1'b0;
      rd_en     = 1'b0;
      rst       = 1'b0;
      check("mrst_count", 32'(count), 32'd0);
      check("mrst_empty", 32'(empty), 32'd1);
      check("mrst_full", 32'(full), 32'd0);
      check("mrst_rd_valid", 32'(rd_valid), 32'd0);
      check("mrst_rd_data", 32'(rd_data), 32'h00);
      check("mrst_overflow", 32'(overflow), 32'd0);
`ifdef PS2_KEY_FIFO_FILTER_EN
      check("mrst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
      tick();
      check("mrst_pipe_discard", 32'(count), 32'd0);
      push(8'h55);
      pop("post_rst_pop", 8'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
Downstream consumer of the PS/2 scan stage. Captures each released-key event (one-cycle strobe plus 8-bit ASCII code) into a small synchronous FIFO so slower logic (display writer, command parser) can drain keystrokes at its own pace without losing any. Sits between the scan stage and any application-side reader; the read side uses a registered rd_en/rd_valid handshake.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
SAMPLE_DLY, 1, clocks between key_valid strobe and the cycle key_code is sampled. The scan stage registers its ASCII lookup one clock after its strobe, so 1 is the default; 0 = sample in the strobe cycle; legal range 0..3.

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
key_valid  in  1  one-cycle strobe, one per key event
key_code  in  8  ASCII code; 8'hFE = unmapped key
rd_en  in  1  read request
clr_ovf  in  1  clears the overflow flag
rd_data  out  8  popped code, valid while rd_valid=1
rd_valid  out  1  one-cycle strobe, one clock after an accepted rd_en
empty  out  1  FIFO holds 0 entries
full  out  1  FIFO holds DEPTH entries
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at posedge): pointers=0, count=0, empty=1, full=0, rd_valid=0, rd_data=8'h00, overflow=0, sample pipeline cleared. Strobes already inside the sample pipeline are discarded.
- Sample pipeline: key_valid is delayed SAMPLE_DLY clocks through a shift register. The delayed strobe is wr_req, and key_code is sampled in that same cycle. Back-to-back strobes are each carried separately.
- Write: on wr_req, if count<DEPTH or a read is accepted in the same cycle, store the code at wr_ptr and increment wr_ptr modulo DEPTH.
- If wr_req arrives while full and no read is accepted in that cycle, the code is dropped and overflow is set to 1.
- Read: rd_en is accepted only when empty=0. An accepted read registers mem[rd_ptr] to rd_data, pulses rd_valid high for one clock on the next cycle, and increments rd_ptr modulo DEPTH.
- rd_en while empty: ignored; rd_valid stays 0 and rd_data holds its value. There is no write-to-read bypass: a write and a read requested in the same cycle while empty performs only the write.
- Simultaneous accepted read and write: count is unchanged. When full, the write goes into the slot freed by the read.
- count: +1 on write only, -1 on read only, unchanged on both or neither. empty and full are registered and agree with count in every cycle.
- overflow: cleared by clr_ovf. If clr_ovf and a new drop occur in the same cycle, set wins.
- Pointers wrap with no gap at DEPTH-1 -> 0. FIFO order is strictly preserved.
- No combinational path from inputs to outputs.

Optional Feature:
Macro: PS2_KEY_FIFO_FILTER_EN
- Defined: a wr_req whose sampled code is 8'hFE is discarded. It is not stored, does not set overflow, and does not change count. An extra output, drop_cnt (8 bits), counts discarded codes, saturates at 8'hFF, and is reset to 0.
- Undefined: 8'hFE is stored like any other code, and the drop_cnt port is absent.

Test Plan:
- Reset, then a key_valid pulse with key_code=8'h41 presented one clock later (SAMPLE_DLY=1) -> count=1, empty=0. Then rd_en -> next cycle rd_valid=1, rd_data=8'h41, empty=1.
- Write 16 distinct codes 8'h51..8'h60 with no reads -> full=1, count=16. A 17th write (8'h61) -> overflow=1, count=16. Draining all 16 returns 8'h51..8'h60 in order, and 8'h61 never appears.
- While full, issue wr_req(8'h5A) and rd_en in the same cycle -> count stays 16, the oldest entry is popped, and 8'h5A appears last when the FIFO is drained.
- rd_en while empty, with a simultaneous write of 8'h4D -> no rd_valid that cycle, count=1. The next rd_en returns 8'h4D.
- With overflow=1, assert clr_ovf in the same cycle as a new drop -> overflow stays 1. A subsequent clr_ovf alone -> overflow=0.
- With PS2_KEY_FIFO_FILTER_EN defined, write 8'hFE then 8'h45 -> count=1, drop_cnt=1, and the read returns 8'h45. Asserting rst mid-stream -> all outputs return to their reset values the next cycle.
